instr_mem_loadable: RTL and testbench
=====================================

INSTR_MEM_LOADABLE -- requirements
Module: instr_mem_loadable

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-high.
REQ-002 Parameter DATA_W, default 32, SHALL set the instruction word width.
REQ-003 Parameter ADDR_W, default 5, SHALL set the fetch address width.
REQ-004 Parameter DEPTH, default 32, SHALL set the stored word count; legal range 2..2**ADDR_W.
REQ-005 Port clk, input, 1, SHALL be the only clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, SHALL be the asynchronous active-high reset.
REQ-007 Port load_start, input, 1, SHALL request a new program-load session.
REQ-008 Port load_valid, input, 1, SHALL qualify load_data.
REQ-009 Port load_data, input, DATA_W, SHALL carry one program word.
REQ-010 Port loading, output, 1, SHALL be high while a load session is open.
REQ-011 Port load_done, output, 1, SHALL pulse one cycle when the last word is written.
REQ-012 Port fetch_req, input, 1, SHALL request one instruction read.
REQ-013 Port fetch_addr, input, ADDR_W, SHALL carry the word address for fetch_req.
REQ-014 Port fetch_ready, output, 1, SHALL be high when fetches are accepted.
REQ-015 Port instru, output, DATA_W, SHALL carry the fetched instruction word.
REQ-016 Port instru_valid, output, 1, SHALL mark instru valid for one cycle.
REQ-017 Port fault, output, 1, SHALL be a sticky out-of-range fetch flag.

Function
REQ-018 The controller SHALL have states EMPTY, LOAD and RUN.
REQ-019 Transitions: EMPTY or RUN with load_start -> LOAD; LOAD after DEPTH accepted words -> RUN; all other cases hold state.
REQ-020 Entering LOAD SHALL clear the write pointer to 0; load_start while in LOAD SHALL be ignored.
REQ-021 In LOAD, each cycle with load_valid=1 SHALL write load_data to mem[wptr] and increment wptr.
REQ-022 The write of word DEPTH-1 SHALL assert load_done the same cycle it is written, return wptr to 0, and move the state to RUN on the next cycle.
REQ-023 load_valid outside LOAD SHALL be ignored; memory SHALL be unchanged.
REQ-024 loading SHALL equal (state==LOAD); fetch_ready SHALL equal (state==RUN).
REQ-025 A fetch is accepted when fetch_req and fetch_ready are both 1; instru and instru_valid SHALL appear exactly one cycle later (latency 1).
REQ-026 Back-to-back fetches SHALL be accepted every cycle at full throughput.
REQ-027 Accepted fetch with fetch_addr<DEPTH SHALL return mem[fetch_addr].
REQ-028 Accepted fetch with fetch_addr>=DEPTH SHALL return NOP_WORD (all zeros), assert instru_valid, and set fault.
REQ-029 fetch_req with fetch_ready=0 SHALL be dropped: no instru_valid and no fault update.
REQ-030 If load_start and an accepted fetch occur in the same RUN cycle, the fetch SHALL complete normally with pre-load data, and LOAD SHALL be entered next cycle.
REQ-031 instru SHALL hold its last value when instru_valid=0.
REQ-032 fault SHALL stay set until reset.

Reset
REQ-033 Reset SHALL force state=EMPTY, wptr=0, loading=0, load_done=0, instru_valid=0, instru=0 and fault=0, asynchronously.
REQ-034 Memory contents SHALL NOT be reset; a reset during LOAD SHALL abandon the session, and a new load_start SHALL be required before fetches are accepted.

Structure
REQ-035 Package instr_mem_pkg SHALL hold the state enum (EMPTY, LOAD, RUN) and the NOP_WORD constant.
REQ-036 Storage SHALL be sub-module instr_mem_array, with one synchronous write port and one synchronous read port, parametrised by DATA_W and DEPTH.
REQ-037 The controller, write pointer, and fault logic SHALL reside in instr_mem_loadable.

Verification
REQ-038 Reset, then fetch_req=1 with addr 0 -> fetch_ready=0 and no instru_valid.
REQ-039 Load 32 words 0x1000+i with gaps in load_valid -> load_done pulses once on word 31; fetch addr 3 -> instru=0x00001003 one cycle later.
REQ-040 Fetch addrs 0,1,2 on consecutive cycles -> instru_valid high for 3 consecutive cycles with words 0x1000, 0x1001, 0x1002.
REQ-041 DEPTH=20 build, fetch addr 25 -> instru=0x00000000, instru_valid=1, fault=1 and still 1 after 10 idle cycles.
REQ-042 In RUN, load_start together with fetch addr 5 -> instru=0x1005, then loading=1; reload with 0xA000+i -> fetch addr 5 returns 0xA005.
REQ-043 Assert reset after 10 words of a load -> all outputs 0 immediately and state EMPTY; fetches are refused until a full reload completes.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam logic [63:0] NOP_WORD = 64'd0;

endpackage

// File: rtl/instr_mem_array.sv
// Word storage: one synchronous write port, one registered read port.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// Instruction memory with a streaming program loader and a fetch port.
module instr_mem_loadable
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              loading,
  output logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instru,
  output logic              instru_valid,
  output logic              fault
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_e            state;
  logic [AW-1:0]     wptr;
  logic              wr_en;
  logic              fetch_acc;
  logic              in_range;
  logic              rd_en;
  logic              valid_q;
  logic              oor_q;
  logic              primed_q;
  logic [DATA_W-1:0] rd_data;

  assign loading     = (state == LOAD);
  assign fetch_ready = (state == RUN);
  assign wr_en       = loading && load_valid;
  assign load_done   = wr_en && (wptr == LAST);
  assign fetch_acc   = fetch_req && fetch_ready;
  assign in_range    = {1'b0, fetch_addr} < DEPTH_L;
  assign rd_en       = fetch_acc && in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      wptr  <= '0;
    end else begin
      unique case (state)
        EMPTY, RUN: begin
          if (load_start) begin
            state <= LOAD;
            wptr  <= '0;
          end
        end
        LOAD: begin
          if (wr_en) begin
            if (wptr == LAST) begin
              wptr  <= '0;
              state <= RUN;
            end else begin
              wptr <= wptr + 1'b1;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // primed_q masks stale array output after reset; oor_q selects the NOP word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      oor_q    <= 1'b0;
      primed_q <= 1'b0;
      fault    <= 1'b0;
    end else begin
      valid_q <= fetch_acc;
      if (fetch_acc) begin
        oor_q    <= !in_range;
        primed_q <= 1'b1;
        if (!in_range) fault <= 1'b1;
      end
    end
  end

  assign instru_valid = valid_q;
  assign instru = (primed_q && !oor_q) ? rd_data : DATA_W'(NOP_WORD);

  instr_mem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wptr),
    .wr_data(load_data),
    .rd_en  (rd_en),
    .rd_addr(fetch_addr[AW-1:0]),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench: DEPTH=32 and DEPTH=20 instances share stimulus; per-cycle scoreboard.
module tb_instr_mem_loadable;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int S_EMPTY = 0;
  localparam int S_LOAD  = 1;
  localparam int S_RUN   = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;

  logic [1:0]    loading, load_done, fetch_ready, instru_valid, fault;
  logic [DW-1:0] instru [2];

  always #5 clk = ~clk;

  instr_mem_loadable #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32)) u_dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .loading(loading[0]), .load_done(load_done[0]),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready[0]), .instru(instru[0]),
    .instru_valid(instru_valid[0]), .fault(fault[0])
  );

  instr_mem_loadable #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(20)) u_dut20 (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .loading(loading[1]), .load_done(load_done[1]),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready[1]), .instru(instru[1]),
    .instru_valid(instru_valid[1]), .fault(fault[1])
  );

  typedef struct packed {
    logic [1:0]         v;
    logic [1:0]         f;
    logic [1:0][DW-1:0] d;
  } exp_t;

  exp_t          sb_q[$];
  int            dep [2] = '{32, 20};
  int            st [2];
  int            wp [2];
  logic [DW-1:0] mm [2][32];
  logic          mf [2];
  logic [DW-1:0] last [2];
  int            done_cnt [2];
  int            errs = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%h want=%h @%0t", tag, got, want, $time);
    end
  endtask

  task automatic drive(input logic ls, input logic lv,
                       input logic [DW-1:0] ld, input logic fr,
                       input logic [AW-1:0] fa);
    exp_t e;
    logic acc;
    e = '0;
    load_start = ls;
    load_valid = lv;
    load_data  = ld;
    fetch_req  = fr;
    fetch_addr = fa;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("loading%0d", k), 32'(loading[k]), 32'(st[k] == S_LOAD));
      check($sformatf("ready%0d", k), 32'(fetch_ready[k]), 32'(st[k] == S_RUN));
      check($sformatf("done%0d", k), 32'(load_done[k]),
            32'(st[k] == S_LOAD && lv && wp[k] == dep[k] - 1));
      if (load_done[k]) done_cnt[k]++;
      acc = fr && (st[k] == S_RUN);
      if (acc) begin
        if (int'(fa) < dep[k]) begin
          last[k] = mm[k][fa];
        end else begin
          last[k] = '0;
          mf[k] = 1'b1;
        end
      end
      e.v[k] = acc;
      e.f[k] = mf[k];
      e.d[k] = last[k];
      if (st[k] == S_LOAD) begin
        if (lv) begin
          mm[k][wp[k]] = ld;
          if (wp[k] == dep[k] - 1) begin
            wp[k] = 0;
            st[k] = S_RUN;
          end else begin
            wp[k]++;
          end
        end
      end else if (ls) begin
        st[k] = S_LOAD;
        wp[k] = 0;
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("ivalid%0d", k), 32'(instru_valid[k]), 32'(e.v[k]));
      check($sformatf("instru%0d", k), instru[k], e.d[k]);
      check($sformatf("fault%0d", k), 32'(fault[k]), 32'(e.f[k]));
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    drive(1'b0, 1'b0, '0, 1'b1, a);
  endtask

  task automatic do_reset();
    load_start = 1'b0;
    load_valid = 1'b0;
    fetch_req  = 1'b0;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_loading%0d", k), 32'(loading[k]), 32'd0);
      check($sformatf("rst_done%0d", k), 32'(load_done[k]), 32'd0);
      check($sformatf("rst_ready%0d", k), 32'(fetch_ready[k]), 32'd0);
      check($sformatf("rst_ivalid%0d", k), 32'(instru_valid[k]), 32'd0);
      check($sformatf("rst_instru%0d", k), instru[k], 32'd0);
      check($sformatf("rst_fault%0d", k), 32'(fault[k]), 32'd0);
      st[k] = S_EMPTY;
      wp[k] = 0;
      mf[k] = 1'b0;
      last[k] = '0;
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_prog(input logic [DW-1:0] base, input bit gaps,
                           input bit start);
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    if (start) drive(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 32; i++) begin
      if (gaps && (i % 4 == 2)) idle();
      drive(1'b0, 1'b1, base + DW'(i), 1'b0, '0);
    end
    check("done_pulses0", 32'(done_cnt[0]), 32'd1);
    check("done_pulses1", 32'(done_cnt[1]), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    do_reset();
    repeat (3) fetch(5'd0);
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, '0);
    load_prog(32'h1000, 1'b1, 1'b1);
    fetch(5'd3);
    fetch(5'd0);
    fetch(5'd1);
    fetch(5'd2);
    idle();
    fetch(5'd19);
    fetch(5'd20);
    fetch(5'd31);
    fetch(5'd25);
    repeat (10) idle();
    drive(1'b1, 1'b0, '0, 1'b1, 5'd5);
    idle();
    load_prog(32'hA000, 1'b0, 1'b0);
    fetch(5'd5);
    fetch(5'd25);
    idle();
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 32'h3000 + DW'(i), 1'b0, '0);
    do_reset();
    fetch(5'd5);
    fetch(5'd25);
    fetch(5'd0);
    load_prog(32'h2000, 1'b1, 1'b1);
    fetch(5'd5);
    fetch(5'd31);
    fetch(5'd25);
    idle();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
